// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared key FSM state type and 25 MHz default timing constants
`timescale 1ns/1ps
package clock_pkg;

    localparam int unsigned SYS_CLK_HZ          = 25_000_000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = SYS_CLK_HZ / 100;
    localparam int unsigned DEF_LONG_CYCLES     = SYS_CLK_HZ;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DEB = 3'd1,
        HELD      = 3'd2,
        LONG      = 3'd3,
        REL_DEB   = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_press_classifier_if.sv
// rtl/key_press_classifier_if.sv - raw key input and classified key event outputs
`timescale 1ns/1ps
interface key_press_classifier_if;

    logic key_raw;
    logic key_short;
    logic key_long;
    logic key_level;

    modport master (
        input  key_raw,
        output key_short,
        output key_long,
        output key_level
    );

    modport slave (
        output key_raw,
        input  key_short,
        input  key_long,
        input  key_level
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with configurable reset value
`timescale 1ns/1ps
module sync_2ff #(
    parameter int              WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_press_classifier.sv
// rtl/key_press_classifier.sv - debounces one key and reports short/long presses
`timescale 1ns/1ps
module key_press_classifier
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    key_press_classifier_if.master  key_bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_FIRST = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
    localparam bit            DEB_ONE   = (DEBOUNCE_CYCLES == 1);
    localparam logic          IDLE_PIN  = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic raw_sync;
    logic key_sync;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (IDLE_PIN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_bus.key_raw),
        .q     (raw_sync)
    );

    assign key_sync = KEY_ACTIVE_LOW ? ~raw_sync : raw_sync;

    key_state_t      state,     state_nxt;
    logic [DW-1:0]   deb_cnt,   deb_nxt;
    logic [HW-1:0]   hold_cnt,  hold_nxt;
    logic            hold_flag, flag_nxt;
    logic            level_q,   level_nxt;
    logic            short_q,   short_nxt;
    logic            long_q,    long_nxt;
    logic            rel_req;
    logic            rel_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            hold_flag <= 1'b0;
            level_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            deb_cnt   <= deb_nxt;
            hold_cnt  <= hold_nxt;
            hold_flag <= flag_nxt;
            level_q   <= level_nxt;
            short_q   <= short_nxt;
            long_q    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        flag_nxt  = hold_flag;
        level_nxt = level_q;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        rel_req   = 1'b0;
        rel_flag  = 1'b0;

        case (state)
            IDLE: begin
                level_nxt = 1'b0;
                if (key_sync) begin
                    if (DEB_ONE) begin
                        state_nxt = HELD;
                        level_nxt = 1'b1;
                        hold_nxt  = '0;
                        flag_nxt  = 1'b0;
                    end else begin
                        state_nxt = PRESS_DEB;
                        deb_nxt   = DEB_FIRST;
                    end
                end
            end

            PRESS_DEB: begin
                if (!key_sync) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                    level_nxt = 1'b1;
                    hold_nxt  = '0;
                    flag_nxt  = 1'b0;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end

            HELD: begin
                // The long threshold wins over a release sampled on the same edge.
                if (hold_cnt >= HOLD_LAST) begin
                    long_nxt = 1'b1;
                    hold_nxt = HOLD_MAX;
                    if (key_sync) begin
                        state_nxt = LONG;
                        flag_nxt  = 1'b1;
                    end else begin
                        rel_req  = 1'b1;
                        rel_flag = 1'b1;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                    if (!key_sync) begin
                        rel_req  = 1'b1;
                        rel_flag = 1'b0;
                    end
                end
            end

            LONG: begin
                if (!key_sync) begin
                    rel_req  = 1'b1;
                    rel_flag = 1'b1;
                end
            end

            REL_DEB: begin
                // hold_cnt stays frozen here so a glitch only delays the long report.
                if (key_sync) begin
                    state_nxt = hold_flag ? LONG : HELD;
                    deb_nxt   = '0;
                end else if (deb_cnt >= DEB_LAST) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                    flag_nxt  = 1'b0;
                    level_nxt = 1'b0;
                    short_nxt = ~hold_flag;
                end else begin
                    deb_nxt = deb_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
                hold_nxt  = '0;
                flag_nxt  = 1'b0;
                level_nxt = 1'b0;
            end
        endcase

        // The first released sample already counts toward the release debounce.
        if (rel_req) begin
            if (DEB_ONE) begin
                state_nxt = IDLE;
                deb_nxt   = '0;
                hold_nxt  = '0;
                flag_nxt  = 1'b0;
                level_nxt = 1'b0;
                short_nxt = ~rel_flag;
            end else begin
                state_nxt = REL_DEB;
                deb_nxt   = DEB_FIRST;
                flag_nxt  = rel_flag;
            end
        end
    end

    assign key_bus.key_short = short_q;
    assign key_bus.key_long  = long_q;
    assign key_bus.key_level = level_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// tb/tb_key_press_classifier.sv - self-checking bench for key_press_classifier
`timescale 1ns/1ps
module tb_key_press_classifier;

    localparam int D = 4;
    localparam int L = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    key_press_classifier_if kif ();

    key_press_classifier #(
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L),
        .KEY_ACTIVE_LOW  (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_bus (kif.master)
    );

    always #20 clk = ~clk;

    typedef enum int {EV_UP = 0, EV_DOWN = 1, EV_SHORT = 2, EV_LONG = 3} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    typedef struct {
        int hi;
        bit exp_accept;
        bit exp_long;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[6];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic prev_level = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: unexpected kind %0d at cycle %0d", k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                         k, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Turns output activity into events and scores them against the expected queue.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_level = 1'b0;
        end else begin
            if (kif.key_level && !prev_level) observe(EV_UP);
            if (!kif.key_level && prev_level) observe(EV_DOWN);
            if (kif.key_short) observe(EV_SHORT);
            if (kif.key_long)  observe(EV_LONG);
            prev_level = kif.key_level;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        check({name, " pending events"}, exp_q.size(), 0);
        check({name, " level idle"}, int'(kif.key_level), 0);
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;

        vecs[0] = '{hi: 3,  exp_accept: 1'b0, exp_long: 1'b0};
        vecs[1] = '{hi: 4,  exp_accept: 1'b1, exp_long: 1'b0};
        vecs[2] = '{hi: 12, exp_accept: 1'b1, exp_long: 1'b0};
        vecs[3] = '{hi: 22, exp_accept: 1'b1, exp_long: 1'b0};
        vecs[4] = '{hi: 23, exp_accept: 1'b1, exp_long: 1'b1};
        vecs[5] = '{hi: 40, exp_accept: 1'b1, exp_long: 1'b1};

        kif.key_raw = 1'b1;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset key_short", int'(kif.key_short), 0);
        check("reset key_long",  int'(kif.key_long),  0);
        check("reset key_level", int'(kif.key_level), 0);
        kif.key_raw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drain("post reset");

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            c0 = cyc;
            if (vecs[i].exp_accept) begin
                push(EV_UP, c0 + 2 + D);
                if (vecs[i].exp_long) push(EV_LONG, c0 + 2 + D + L);
                push(EV_DOWN, c0 + vecs[i].hi + 2 + D);
                if (!vecs[i].exp_long) push(EV_SHORT, c0 + vecs[i].hi + 2 + D);
            end
            kif.key_raw = 1'b1;
            repeat (vecs[i].hi) @(negedge clk);
            kif.key_raw = 1'b0;
            drain($sformatf("press %0d", vecs[i].hi));
        end

        @(negedge clk);
        for (int r = 0; r < 5; r++) begin
            kif.key_raw = 1'b1;
            repeat (3) @(negedge clk);
            kif.key_raw = 1'b0;
            @(negedge clk);
        end
        drain("press bounce");

        @(negedge clk);
        c0 = cyc;
        push(EV_UP,    c0 + 6);
        push(EV_DOWN,  c0 + 27);
        push(EV_SHORT, c0 + 27);
        kif.key_raw = 1'b1;
        repeat (14) @(negedge clk);
        kif.key_raw = 1'b0;
        repeat (2) @(negedge clk);
        kif.key_raw = 1'b1;
        repeat (5) @(negedge clk);
        kif.key_raw = 1'b0;
        drain("release glitch short");

        @(negedge clk);
        c0 = cyc;
        push(EV_UP,   c0 + 6);
        push(EV_LONG, c0 + 28);
        push(EV_DOWN, c0 + 46);
        kif.key_raw = 1'b1;
        repeat (14) @(negedge clk);
        kif.key_raw = 1'b0;
        repeat (2) @(negedge clk);
        kif.key_raw = 1'b1;
        repeat (24) @(negedge clk);
        kif.key_raw = 1'b0;
        drain("release glitch long");

        @(negedge clk);
        c0 = cyc;
        push(EV_UP, c0 + 6);
        kif.key_raw = 1'b1;
        repeat (10) @(negedge clk);
        check("mid-press level before reset", int'(kif.key_level), 1);
        rst_n = 1'b0;
        #1;
        check("mid-press level in reset", int'(kif.key_level), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        kif.key_raw = 1'b0;
        drain("aborted press");

        @(negedge clk);
        c0 = cyc;
        push(EV_UP,    c0 + 6);
        push(EV_DOWN,  c0 + 18);
        push(EV_SHORT, c0 + 18);
        kif.key_raw = 1'b1;
        repeat (12) @(negedge clk);
        kif.key_raw = 1'b0;
        drain("press after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_press_classifier.md
# key_press_classifier

Debounces one raw push-button input and classifies each press as short or long. It emits single-cycle `key_short` / `key_long` pulses plus a debounced level. It sits directly upstream of the clock state machine (`clock_sm`), whose `key_short` / `key_long` inputs it drives. One instance is used per physical key.

## Interface
- `DEBOUNCE_CYCLES`, default 250000 (10 ms @ 25 MHz): consecutive stable synchronized samples required to accept a press or release; must be ≥ 1.
- `LONG_CYCLES`, default 25000000 (1 s @ 25 MHz): held duration after press acceptance that qualifies as long; must be ≥ 1.
- `KEY_ACTIVE_LOW`, default 1: 1 = button pulls `key_raw` low when pressed.
- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_raw`  in  1  raw button pin, asynchronous to `clk`, may bounce.
- `key_short`  out  1  one-cycle pulse: press released before reaching the long threshold.
- `key_long`  out  1  one-cycle pulse: press held for `LONG_CYCLES`.
- `key_level`  out  1  debounced pressed state, 1 = pressed.

## Operation
- Input stage: 2-flop synchronizer, then polarity normalization; the result is `key_sync`, where 1 = pressed. The synchronizer flops reset to the *not pressed* level.
- Two counters:
  - `deb_cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - `hold_cnt`, width `$clog2(LONG_CYCLES+1)`, saturates and never wraps.
- FSM states, with `hold_flag` recording whether a long press was already reported:
  - IDLE: `key_level`=0. `key_sync`=1 → PRESS_DEB, `deb_cnt`=1.
  - PRESS_DEB: `key_sync`=0 → IDLE (bounce rejected). `deb_cnt` reaches `DEBOUNCE_CYCLES` → HELD, `key_level`←1, `hold_cnt`←0.
  - HELD: `hold_cnt` increments each cycle. Reaching `LONG_CYCLES` → pulse `key_long`, go to LONG. Otherwise `key_sync`=0 → REL_DEB with `hold_flag`=0.
  - LONG: `key_sync`=0 → REL_DEB with `hold_flag`=1. No further pulses while held.
  - REL_DEB: `hold_cnt` is frozen.
    - `key_sync`=1 → return to HELD (`hold_flag`=0) or LONG (`hold_flag`=1). The glitch is ignored and `hold_cnt` is not cleared.
    - Inactive count reaches `DEBOUNCE_CYCLES` → IDLE, `key_level`←0. If `hold_flag`=0, pulse `key_short` on the same edge.
- Simultaneous threshold hit and release in HELD: the long threshold wins. `key_long` pulses and the FSM goes to REL_DEB with `hold_flag`=1.
- Exactly one of `key_short` / `key_long` fires per accepted press, never both, never twice. A bounce that fails debounce produces nothing.

## Timing
- Reset (async assert, sync release): state IDLE, counters 0, `key_short`=0, `key_long`=0, `key_level`=0.
- Reset asserted mid-press aborts the press; no pulse is emitted for it.
- Press acceptance: `key_level` rises on the (2+`DEBOUNCE_CYCLES`)-th rising edge after the first edge that samples `key_raw` pressed, provided the pin stays pressed throughout.
- `key_long` is high for exactly the one cycle that starts `LONG_CYCLES` edges after `key_level` rises, assuming no release glitches. Each REL_DEB cycle in between delays it by one edge.
- Release: `key_level` falls and `key_short` (if due) pulses on the (2+`DEBOUNCE_CYCLES`)-th edge after the first edge that samples `key_raw` released.
- All outputs are registered, with no combinational path from `key_raw`. Pulses are exactly one `clk` cycle wide, so `clock_sm` advances once per pulse.

## Structure
- Shared package `clock_pkg`: the FSM state enum `key_state_t` (IDLE, PRESS_DEB, HELD, LONG, REL_DEB) and the default cycle constants for the 25 MHz system clock.
- One natural sub-module, `sync_2ff`: a generic 2-flop synchronizer with a reset value parameter, reusable for the other asynchronous inputs.
- Counters and FSM stay in `key_press_classifier`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, `KEY_ACTIVE_LOW`=0, `clk` period 40 ns.
- Reset: hold `rst_n`=0 with `key_raw`=1 → all outputs 0; no pulse after release of reset while still in the stable reset condition.
- Clean short press: `key_raw` high for 12 cycles → `key_level` high from edge 6 after press. Exactly one `key_short` pulse 6 edges after release sampling. `key_long` stays 0.
- Long press: `key_raw` high for 40 cycles → one `key_long` pulse 20 edges after `key_level` rises. No `key_short` on release; `key_level` falls 6 edges after release.
- Press bounce: toggle `key_raw` 3 high / 1 low, repeated 5×, then low → no pulses, `key_level` stays 0.
- Release glitch: after acceptance, a 2-cycle low glitch at hold_cnt=8, then held until 15 cycles total, then released → single `key_short` only at final release. `key_level` never drops during the glitch.
- Reset mid-press: assert `rst_n`=0 while in HELD, deassert with key still pressed, then release → no pulses from the aborted press. A new full press is detected normally afterwards.
